// File: rtl/edm_pkg.sv
// Shared types and constants for the EDM discharge pulse generator.
package edm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TON,
    TOFF
  } state_t;

  localparam logic [1:0] WF_SYNC   = 2'd0;
  localparam logic [1:0] WF_ROTATE = 2'd1;

  localparam int N_CH_DEF        = 8;
  localparam int TICK_CYCLES_DEF = 10;
  localparam int TON_MIN_DEF     = 1;
  localparam int TOFF_MIN_DEF    = 2;

  function automatic logic [15:0] clamp_lo(
    input logic [15:0] v,
    input logic [15:0] lo
  );
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Tick prescaler plus 16-bit tick down-counter; done marks the
// final clock cycle of the loaded interval.
module pulse_timer #(
  parameter int TICK_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        done
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] presc;
  logic [15:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
    end else if (load) begin
      presc <= '0;
      cnt   <= load_val;
    end else if (presc == LAST) begin
      presc <= '0;
      cnt   <= cnt - 16'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign done = (cnt == 16'd1) && (presc == LAST);

endmodule

// File: rtl/pulse_generator.sv
// Ton/Toff discharge pulse generator: SPI command strobes in,
// MOSFET gate and cut-switch drive out.
module pulse_generator
  import edm_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int TON_MIN     = TON_MIN_DEF,
  parameter int TOFF_MIN    = TOFF_MIN_DEF,
  parameter int N_CH        = N_CH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            machine_start_ack,
  input  logic            machine_stop_ack,
  input  logic [15:0]     Ton_data,
  input  logic            change_Ton_ack,
  input  logic [15:0]     Toff_data,
  input  logic            change_Toff_ack,
  input  logic [15:0]     Ip_data,
  input  logic            change_Ip_ack,
  input  logic [15:0]     waveform_data,
  input  logic            change_waveform_ack,
  input  logic            short_flag,
  output logic [N_CH-1:0] PWM,
  output logic [1:0]      PWM_Q,
  output logic            running,
  output logic            pulse_start,
  output logic [15:0]     pulse_cnt,
  output logic [15:0]     short_cnt
);

  localparam int RW = $clog2(N_CH);

  state_t state, state_nxt;

  logic [15:0]   p_ton;
  logic [15:0]   p_toff;
  logic [3:0]    p_ip;
  logic [1:0]    p_mode;
  logic [15:0]   act_toff;
  logic [RW-1:0] rot;

  logic [15:0]     ton_eff;
  logic [15:0]     toff_eff;
  logic [4:0]      ch;
  logic [N_CH-1:0] base;
  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0] mask;

  logic        ent_ton;
  logic        ent_toff;
  logic        short_hit;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_done;

  logic unused_bits;
  assign unused_bits = ^{Ip_data[15:4], waveform_data[15:2]};

  assign ton_eff  = clamp_lo(p_ton, 16'(TON_MIN));
  assign toff_eff = clamp_lo(p_toff, 16'(TOFF_MIN));

  // Mask for the pulse about to start, built from pending settings.
  always_comb begin
    ch = ({1'b0, p_ip} > 5'(N_CH)) ? 5'(N_CH) : {1'b0, p_ip};
    for (int i = 0; i < N_CH; i++) begin
      base[i] = (5'(i) < ch);
    end
    dbl  = {base, base} << rot;
    mask = (p_mode == WF_ROTATE) ? dbl[2*N_CH-1:N_CH] : base;
  end

  always_comb begin
    state_nxt = state;
    ent_ton   = 1'b0;
    ent_toff  = 1'b0;
    short_hit = 1'b0;
    if (machine_stop_ack) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (machine_start_ack) begin
            state_nxt = TON;
            ent_ton   = 1'b1;
          end
        end
        TON: begin
          if (short_flag || tmr_done) begin
            state_nxt = TOFF;
            ent_toff  = 1'b1;
            short_hit = short_flag;
          end
        end
        TOFF: begin
          if (tmr_done) begin
            state_nxt = TON;
            ent_ton   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign tmr_load = ent_ton | ent_toff | machine_stop_ack;
  assign tmr_val  = ent_ton ? ton_eff : act_toff;

  pulse_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_ton       <= 16'(TON_MIN);
      p_toff      <= 16'(TOFF_MIN);
      p_ip        <= '0;
      p_mode      <= WF_SYNC;
      act_toff    <= 16'(TOFF_MIN);
      rot         <= '0;
      PWM         <= '0;
      PWM_Q       <= '0;
      running     <= 1'b0;
      pulse_start <= 1'b0;
      pulse_cnt   <= '0;
      short_cnt   <= '0;
    end else begin
      if (change_Ton_ack)      p_ton  <= Ton_data;
      if (change_Toff_ack)     p_toff <= Toff_data;
      if (change_Ip_ack)       p_ip   <= Ip_data[3:0];
      if (change_waveform_ack) p_mode <= waveform_data[1:0];

      pulse_start <= ent_ton;
      running     <= (state_nxt != IDLE);
      PWM_Q       <= {2{state_nxt != IDLE}};

      if (ent_ton)                PWM <= mask;
      else if (state_nxt != TON)  PWM <= '0;

      if (ent_ton) begin
        act_toff  <= toff_eff;
        rot       <= rot + RW'(1);
        pulse_cnt <= (state == IDLE) ? 16'd1 : pulse_cnt + 16'd1;
      end else if (state_nxt == IDLE) begin
        rot <= '0;
      end

      if (short_hit) short_cnt <= short_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator with hand-computed expectations.
module tb_pulse_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        machine_start_ack;
  logic        machine_stop_ack;
  logic [15:0] Ton_data;
  logic        change_Ton_ack;
  logic [15:0] Toff_data;
  logic        change_Toff_ack;
  logic [15:0] Ip_data;
  logic        change_Ip_ack;
  logic [15:0] waveform_data;
  logic        change_waveform_ack;
  logic        short_flag;
  logic [7:0]  PWM;
  logic [1:0]  PWM_Q;
  logic        running;
  logic        pulse_start;
  logic [15:0] pulse_cnt;
  logic [15:0] short_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  pulse_generator dut (
    .clk                 (clk),
    .rst                 (rst),
    .machine_start_ack   (machine_start_ack),
    .machine_stop_ack    (machine_stop_ack),
    .Ton_data            (Ton_data),
    .change_Ton_ack      (change_Ton_ack),
    .Toff_data           (Toff_data),
    .change_Toff_ack     (change_Toff_ack),
    .Ip_data             (Ip_data),
    .change_Ip_ack       (change_Ip_ack),
    .waveform_data       (waveform_data),
    .change_waveform_ack (change_waveform_ack),
    .short_flag          (short_flag),
    .PWM                 (PWM),
    .PWM_Q               (PWM_Q),
    .running             (running),
    .pulse_start         (pulse_start),
    .pulse_cnt           (pulse_cnt),
    .short_cnt           (short_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] ton, input logic [15:0] toff,
                     input logic [15:0] ip, input logic [15:0] md);
    Ton_data = ton;
    Toff_data = toff;
    Ip_data = ip;
    waveform_data = md;
    change_Ton_ack = 1'b1;
    change_Toff_ack = 1'b1;
    change_Ip_ack = 1'b1;
    change_waveform_ack = 1'b1;
    tick();
    change_Ton_ack = 1'b0;
    change_Toff_ack = 1'b0;
    change_Ip_ack = 1'b0;
    change_waveform_ack = 1'b0;
  endtask

  task automatic start();
    machine_start_ack = 1'b1;
    tick();
    machine_start_ack = 1'b0;
  endtask

  task automatic stop();
    machine_stop_ack = 1'b1;
    tick();
    machine_stop_ack = 1'b0;
  endtask

  // Cycles PWM holds lvl, starting with the current cycle.
  task automatic meas(input logic [7:0] lvl, output int cnt);
    cnt = 0;
    while (PWM === lvl && cnt < 3000) begin
      cnt++;
      tick();
    end
  endtask

  logic [7:0] rot_tbl [9] = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70,
                              8'hE0, 8'hC1, 8'h83, 8'h07};

  initial begin
    rst = 1'b1;
    machine_start_ack = 1'b0;
    machine_stop_ack = 1'b0;
    Ton_data = '0;
    Toff_data = '0;
    Ip_data = '0;
    waveform_data = '0;
    change_Ton_ack = 1'b0;
    change_Toff_ack = 1'b0;
    change_Ip_ack = 1'b0;
    change_waveform_ack = 1'b0;
    short_flag = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_pwm", 32'(PWM), 0);
    chk("rst_pwmq", 32'(PWM_Q), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_ps", 32'(pulse_start), 0);
    chk("rst_pcnt", 32'(pulse_cnt), 0);
    chk("rst_scnt", 32'(short_cnt), 0);

    // Ton=5 Toff=10 all channels, sync
    cfg(16'd5, 16'd10, 16'd8, 16'd0);
    start();
    chk("t1_pwm", 32'(PWM), 32'hFF);
    chk("t1_pwmq", 32'(PWM_Q), 3);
    chk("t1_run", 32'(running), 1);
    chk("t1_ps", 32'(pulse_start), 1);
    chk("t1_pcnt", 32'(pulse_cnt), 1);
    meas(8'hFF, n);
    chk("t1_hi", 32'(n), 50);
    chk("t1_ps_off", 32'(pulse_start), 0);
    chk("t1_q_toff", 32'(PWM_Q), 3);
    meas(8'h00, n);
    chk("t1_lo", 32'(n), 100);
    chk("t1_ps2", 32'(pulse_start), 1);
    chk("t1_pcnt2", 32'(pulse_cnt), 2);
    meas(8'hFF, n);
    chk("t1_hi2", 32'(n), 50);
    meas(8'h00, n);
    chk("t1_lo2", 32'(n), 100);
    repeat (20) tick();
    stop();
    chk("stop_pwm", 32'(PWM), 0);
    chk("stop_pwmq", 32'(PWM_Q), 0);
    chk("stop_run", 32'(running), 0);

    // zero Ton/Toff clamp, Ip above channel count
    cfg(16'd0, 16'd0, 16'd12, 16'd0);
    start();
    chk("t2_pwm", 32'(PWM), 32'hFF);
    meas(8'hFF, n);
    chk("t2_hi", 32'(n), 10);
    meas(8'h00, n);
    chk("t2_lo", 32'(n), 20);
    chk("t2_ps", 32'(pulse_start), 1);
    stop();
    chk("t2_run", 32'(running), 0);

    // rotating 3-channel mask
    cfg(16'd1, 16'd2, 16'd3, 16'd1);
    start();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("rot%0d", k), 32'(PWM), 32'(rot_tbl[k]));
      if (k < 8) begin
        meas(PWM, n);
        meas(8'h00, n);
      end
    end
    chk("rot_pcnt", 32'(pulse_cnt), 9);
    stop();
    start();
    chk("rot_clr", 32'(PWM), 32'h07);
    stop();

    // short detection cuts Ton
    cfg(16'd20, 16'd3, 16'd8, 16'd0);
    start();
    repeat (6) tick();
    chk("sh_pre", 32'(PWM), 32'hFF);
    short_flag = 1'b1;
    tick();
    short_flag = 1'b0;
    chk("sh_pwm", 32'(PWM), 0);
    chk("sh_pwmq", 32'(PWM_Q), 3);
    chk("sh_cnt", 32'(short_cnt), 1);
    meas(8'h00, n);
    chk("sh_toff", 32'(n), 30);
    meas(8'hFF, n);
    chk("sh_ton_full", 32'(n), 200);
    short_flag = 1'b1;
    meas(8'h00, n);
    short_flag = 1'b0;
    chk("sh_toff_ign", 32'(n), 30);
    chk("sh_cnt2", 32'(short_cnt), 1);
    stop();
    short_flag = 1'b1;
    tick();
    short_flag = 1'b0;
    chk("sh_idle_ign", 32'(short_cnt), 1);
    chk("sh_idle_run", 32'(running), 0);

    // Ton update mid-TOFF and on TON entry
    cfg(16'd3, 16'd2, 16'd8, 16'd0);
    start();
    meas(8'hFF, n);
    chk("up_hi0", 32'(n), 30);
    repeat (5) tick();
    Ton_data = 16'd8;
    change_Ton_ack = 1'b1;
    tick();
    change_Ton_ack = 1'b0;
    meas(8'h00, n);
    chk("up_lo_rest", 32'(n), 14);
    meas(8'hFF, n);
    chk("up_hi1", 32'(n), 80);
    repeat (19) tick();
    Ton_data = 16'd4;
    change_Ton_ack = 1'b1;
    tick();
    change_Ton_ack = 1'b0;
    chk("up_ps", 32'(pulse_start), 1);
    meas(8'hFF, n);
    chk("up_hi2", 32'(n), 80);
    meas(8'h00, n);
    chk("up_lo2", 32'(n), 20);
    meas(8'hFF, n);
    chk("up_hi3", 32'(n), 40);
    stop();

    // start and stop together
    machine_start_ack = 1'b1;
    machine_stop_ack = 1'b1;
    tick();
    machine_start_ack = 1'b0;
    machine_stop_ack = 1'b0;
    chk("ss_run", 32'(running), 0);
    chk("ss_ps", 32'(pulse_start), 0);
    chk("ss_pwmq", 32'(PWM_Q), 0);
    chk("ss_pwm", 32'(PWM), 0);

    // start while running is ignored
    start();
    repeat (3) tick();
    start();
    chk("rs_ps", 32'(pulse_start), 0);
    chk("rs_pcnt", 32'(pulse_cnt), 1);
    meas(8'hFF, n);
    chk("rs_hi", 32'(n), 36);

    // reset mid-TOFF
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_pwm", 32'(PWM), 0);
    chk("rr_pwmq", 32'(PWM_Q), 0);
    chk("rr_run", 32'(running), 0);
    chk("rr_pcnt", 32'(pulse_cnt), 0);
    chk("rr_scnt", 32'(short_cnt), 0);

    // default pending values: Ton=1, Toff=2, no channels
    start();
    chk("df_run", 32'(running), 1);
    chk("df_pwm", 32'(PWM), 0);
    chk("df_pwmq", 32'(PWM_Q), 3);
    repeat (30) tick();
    chk("df_ps", 32'(pulse_start), 1);
    chk("df_pcnt", 32'(pulse_cnt), 2);
    stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
